// File: rtl/fp_mul_stream_ctrl_if.sv
// Stream interface for fp_mul_stream_ctrl.
// Carries the operand-pair input stream (in_*) and the product output stream (out_*).
//   slave  : block side (accepts operands, presents products)
//   master : producer/consumer side (issues operands, accepts products)
interface fp_mul_stream_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fp_mul_stream_ctrl.sv
// Flow-control wrapper around a free-running single-precision DSP multiplier.
// Operand pairs are accepted on io.in_*, registered onto mul_ay/mul_az, tracked
// through a valid delay line matched to the multiplier latency, and the
// products are captured into an output FIFO drained on io.out_*.
// Credits (fifo_count + inflight) bound issue so a product always has a slot.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   io (slave)          in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_data
//   mul_ena, mul_aclr   multiplier clock enable / async clear
//   mul_ay, mul_az      multiplier operands
//   mul_result          multiplier product
//   fifo_count          products buffered in the FIFO
//   inflight            products issued but not yet captured
module fp_mul_stream_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_mul_stream_ctrl_if.slave  io,
  output logic                 mul_ena,
  output logic [1:0]           mul_aclr,
  output logic [31:0]          mul_ay,
  output logic [31:0]          mul_az,
  input  logic [31:0]          mul_result,
  output logic [CNT_W-1:0]     fifo_count,
  output logic [CNT_W-1:0]     inflight
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Bit 0 is the issue register stage, bit MUL_LATENCY lines up with mul_result.
  logic [MUL_LATENCY:0] vld_dly;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [31:0]          mem [FIFO_DEPTH];
  logic [CNT_W:0]       credit_used;
  logic                 fire;
  logic                 capture;
  logic                 pop;

  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  // mul_ena doubles as an "out of reset" flag so in_ready stays low in reset.
  assign io.in_ready = mul_ena && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign fire        = io.in_valid && io.in_ready;
  assign capture     = vld_dly[MUL_LATENCY];
  assign io.out_valid = (fifo_count != '0);
  assign io.out_data  = mem[rd_ptr];
  assign pop          = io.out_valid && io.out_ready;
  assign mul_aclr     = {2{~rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_ena    <= 1'b0;
      mul_ay     <= '0;
      mul_az     <= '0;
      vld_dly    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      mul_ena <= 1'b1;
      vld_dly <= {vld_dly[MUL_LATENCY-1:0], fire};

      if (fire) begin
        mul_ay <= io.in_a;
        mul_az <= io.in_b;
      end

      if (capture) begin
        mem[wr_ptr] <= mul_result;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end

      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({fire, capture})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase

      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Credit accounting must make these unreachable; there is no recovery path.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && (fifo_count == CNT_W'(FIFO_DEPTH))));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    credit_used <= (CNT_W+1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_fp_mul_stream_ctrl.sv
// Testbench for fp_mul_stream_ctrl: behavioural 3-stage multiplier, directed
// stimulus, expected products queued at issue and checked by a monitor.
module tb_fp_mul_stream_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mul_ena;
  logic [1:0]  mul_aclr;
  logic [31:0] mul_ay, mul_az, mul_result;
  logic [3:0]  fifo_count, inflight;

  fp_mul_stream_ctrl_if io();

  fp_mul_stream_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (io),
    .mul_ena    (mul_ena),
    .mul_aclr   (mul_aclr),
    .mul_ay     (mul_ay),
    .mul_az     (mul_az),
    .mul_result (mul_result),
    .fifo_count (fifo_count),
    .inflight   (inflight)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  int pop_cyc[$];

  always @(posedge clk) cyc++;

  function automatic real sp2r(logic [31:0] a);
    logic [10:0] e;
    if (a[30:23] == 8'd0) return 0.0;
    e = 11'(int'(a[30:23]) - 127 + 1023);
    return $bitstoreal({a[31], e, a[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2sp(real r);
    logic [63:0] d;
    logic [7:0]  e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'b0};
    e = 8'(int'(d[62:52]) - 1023 + 127);
    return {d[63], e, d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
    return r2sp(sp2r(a) * sp2r(b));
  endfunction

  // Exact single-precision encoding of a small non-negative integer.
  function automatic logic [31:0] int_to_sp(int unsigned n);
    int p;
    logic [31:0] m;
    if (n == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 24; i++) if (n[i]) p = i;
    m = n << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  // Multiplier model: product appears MUL_LATENCY=3 edges after mul_ay/mul_az.
  logic [31:0] p0, p1, p2;
  always @(posedge clk or posedge mul_aclr[0]) begin
    if (mul_aclr[0]) begin
      p0 <= '0; p1 <= '0; p2 <= '0;
    end else if (mul_ena) begin
      p0 <= fmul(mul_ay, mul_az);
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign mul_result = p2;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard compare on every handshake, credit bound every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("credit_bound", 32'(int'(fifo_count) + int'(inflight) <= 8), 32'd1);
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%08h expected none", io.out_data);
        end else begin
          chk("out_data", io.out_data, exp_q.pop_front());
        end
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, output int stalls);
    io.in_a = a;
    io.in_b = b;
    io.in_valid = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (io.in_ready) break;
      stalls++;
      if (stalls > 500) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 500 cycles");
        io.in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && fifo_count == 0 && inflight == 0) break;
      step();
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot, fires, first, nval, ra, rb;
    bit rnd_done;
    io.in_valid = 1'b0;
    io.in_a = '0;
    io.in_b = '0;
    io.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(io.in_ready), 32'd0);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_out_data", io.out_data, 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_aclr", 32'(mul_aclr), 32'd3);
    chk("rst_ena", 32'(mul_ena), 32'd0);
    chk("rst_ay", mul_ay, 32'd0);
    chk("rst_az", mul_az, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Idle
    io.out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_ena", 32'(mul_ena), 32'd1);
      chk("idle_aclr", 32'(mul_aclr), 32'd0);
      chk("idle_out_valid", 32'(io.out_valid), 32'd0);
      chk("idle_in_ready", 32'(io.in_ready), 32'd1);
    end
    step();

    // Single pair latency: 2.0 * 3.0
    send(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, st);
    first = 0;
    nval = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (io.out_valid) begin
        nval++;
        if (first == 0) first = c;
      end
    end
    chk("single_latency", 32'(first), 32'd5);
    chk("single_valid_cycles", 32'(nval), 32'd1);
    chk("single_inflight", 32'(inflight), 32'd0);
    step();

    // Burst of 20 back-to-back, k.0 * 1.0
    pop_cyc.delete();
    tot = 0;
    for (int k = 1; k <= 20; k++) begin
      send(int_to_sp(k), 32'h3F80_0000, int_to_sp(k), st);
      tot += st;
    end
    chk("burst_stalls", 32'(tot), 32'd0);
    drain();
    chk("burst_count", 32'(pop_cyc.size()), 32'd20);
    if (pop_cyc.size() == 20)
      chk("burst_consecutive", 32'(pop_cyc[19] - pop_cyc[0]), 32'd19);

    // Backpressure: consumer stalled, producer always valid
    io.out_ready = 1'b0;
    fires = 0;
    io.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      io.in_a = int_to_sp(fires + 1);
      io.in_b = int_to_sp(2);
      @(negedge clk);
      if (io.in_ready) begin
        exp_q.push_back(int_to_sp(2 * (fires + 1)));
        fires++;
      end
      step();
    end
    io.in_valid = 1'b0;
    chk("bp_fires", 32'(fires), 32'd8);
    chk("bp_in_ready_low", 32'(io.in_ready), 32'd0);
    chk("bp_fifo_count", 32'(fifo_count), 32'd8);
    chk("bp_inflight", 32'(inflight), 32'd0);
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_after_pop", 32'(io.in_ready), 32'd1);
    chk("bp_fifo_after_pop", 32'(fifo_count), 32'd7);
    step();
    io.out_ready = 1'b1;
    drain();

    // Random valid/ready, 1000 pairs
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          while ($urandom_range(0, 1) == 0) step();
          ra = $urandom_range(1, 255);
          rb = $urandom_range(1, 255);
          send(int_to_sp(ra), int_to_sp(rb), int_to_sp(ra * rb), st);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          io.out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    io.out_ready = 1'b1;
    drain();

    // Reset with 4 buffered and 3 in flight
    io.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(int_to_sp(k), int_to_sp(5), int_to_sp(5 * k), st);
    repeat (8) step();
    chk("mid_buffered", 32'(fifo_count), 32'd4);
    for (int k = 1; k <= 3; k++) send(int_to_sp(k), int_to_sp(9), int_to_sp(9 * k), st);
    chk("mid_inflight", 32'(inflight), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_inflight", 32'(inflight), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    nval = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (io.out_valid) nval++;
    end
    chk("post_rst_no_stale", 32'(nval), 32'd0);
    step();
    send(int_to_sp(7), int_to_sp(6), int_to_sp(42), st);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
